// File: rtl/mem_arbiter_if.sv
// SRAM-like request/response bus: master drives the request phase, slave returns addr_ok/data_ok/rdata.
interface mem_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data, data-first with starvation guard.
// Optional grant counters behind MEM_ARB_PERF_CNT_EN. One transaction in flight; arbitration adds 1 cycle.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_arbiter_if.slave         inst_if,
    mem_arbiter_if.slave         data_if,
    mem_arbiter_if.master        mem_if
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]          inst_grant_cnt_o,
    output logic [31:0]          data_grant_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;
    typedef enum logic {GNT_INST, GNT_DATA} grant_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e     state_q, state_d;
    grant_e     grant_q, grant_d;
    logic [7:0] starve_q, starve_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= GNT_INST;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
        end
    end

    // Read data is a straight pass-through; masters qualify it with data_ok.
    assign inst_if.rdata = mem_if.rdata;
    assign data_if.rdata = mem_if.rdata;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        starve_d        = starve_q;
        mem_if.req      = 1'b0;
        mem_if.wr       = 1'b0;
        mem_if.size     = 2'd0;
        mem_if.wstrb    = 4'd0;
        mem_if.addr     = 32'd0;
        mem_if.wdata    = 32'd0;
        inst_if.addr_ok = 1'b0;
        inst_if.data_ok = 1'b0;
        data_if.addr_ok = 1'b0;
        data_if.data_ok = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_if.req && (!inst_if.req || starve_q < LIMIT)) begin
                    grant_d = GNT_DATA;
                    state_d = ADDR;
                    if (inst_if.req && starve_q < LIMIT) begin
                        starve_d = starve_q + 8'd1;
                    end
                end else if (inst_if.req) begin
                    grant_d  = GNT_INST;
                    state_d  = ADDR;
                    starve_d = '0;
                end
            end
            ADDR: begin
                if (grant_q == GNT_DATA) begin
                    mem_if.req      = data_if.req;
                    mem_if.wr       = data_if.wr;
                    mem_if.size     = data_if.size;
                    mem_if.wstrb    = data_if.wstrb;
                    mem_if.addr     = data_if.addr;
                    mem_if.wdata    = data_if.wdata;
                    data_if.addr_ok = mem_if.addr_ok & data_if.req;
                end else begin
                    mem_if.req      = inst_if.req;
                    mem_if.size     = 2'd2;
                    mem_if.addr     = inst_if.addr;
                    inst_if.addr_ok = mem_if.addr_ok & inst_if.req;
                end
                // A master withdrawing before acceptance leaves nothing outstanding.
                if (mem_if.req && mem_if.addr_ok) begin
                    state_d = RESP;
                end else if (!mem_if.req) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (grant_q == GNT_DATA) begin
                    data_if.data_ok = mem_if.data_ok;
                end else begin
                    inst_if.data_ok = mem_if.data_ok;
                end
                if (mem_if.data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] inst_cnt_q, data_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            if (inst_if.addr_ok) inst_cnt_q <= inst_cnt_q + 32'd1;
            if (data_if.addr_ok) data_cnt_q <= data_cnt_q + 32'd1;
        end
    end

    assign inst_grant_cnt_o = inst_cnt_q;
    assign data_grant_cnt_o = data_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level reference model checked every cycle, plus directed scenarios.
module tb_mem_arbiter;
    localparam int SL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if inst_bus ();
    mem_arbiter_if data_bus ();
    mem_arbiter_if mem_bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] inst_cnt, data_cnt;
`endif

    mem_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk     (clk),
        .reset   (reset),
        .inst_if (inst_bus.slave),
        .data_if (data_bus.slave),
        .mem_if  (mem_bus.master)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .inst_grant_cnt_o (inst_cnt),
        .data_grant_cnt_o (data_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the port right now and whether its request was taken.
    int owner = 0;          // 0 none, 1 inst, 2 data
    bit accepted = 0;
    int starve = 0;
    int m_inst_cnt = 0, m_data_cnt = 0;

    logic        e_req, e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    logic        e_iaok, e_idok, e_daok, e_ddok;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compute_expect();
        e_req = 0; e_wr = 0; e_size = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
        e_iaok = 0; e_idok = 0; e_daok = 0; e_ddok = 0;
        if (owner == 1 && !accepted) begin
            e_req  = inst_bus.req;
            e_size = 2'd2;
            e_addr = inst_bus.addr;
            e_iaok = inst_bus.req & mem_bus.addr_ok;
        end else if (owner == 2 && !accepted) begin
            e_req   = data_bus.req;
            e_wr    = data_bus.wr;
            e_size  = data_bus.size;
            e_wstrb = data_bus.wstrb;
            e_addr  = data_bus.addr;
            e_wdata = data_bus.wdata;
            e_daok  = data_bus.req & mem_bus.addr_ok;
        end else if (owner != 0 && accepted) begin
            e_idok = (owner == 1) & mem_bus.data_ok;
            e_ddok = (owner == 2) & mem_bus.data_ok;
        end
    endtask

    task automatic eval();
        @(negedge clk);
        compute_expect();
        chk("mem_req", 32'(mem_bus.req), 32'(e_req));
        if (e_req) begin
            chk("mem_wr", 32'(mem_bus.wr), 32'(e_wr));
            chk("mem_size", 32'(mem_bus.size), 32'(e_size));
            chk("mem_wstrb", 32'(mem_bus.wstrb), 32'(e_wstrb));
            chk("mem_addr", mem_bus.addr, e_addr);
            chk("mem_wdata", mem_bus.wdata, e_wdata);
        end
        chk("inst_addr_ok", 32'(inst_bus.addr_ok), 32'(e_iaok));
        chk("inst_data_ok", 32'(inst_bus.data_ok), 32'(e_idok));
        chk("data_addr_ok", 32'(data_bus.addr_ok), 32'(e_daok));
        chk("data_data_ok", 32'(data_bus.data_ok), 32'(e_ddok));
        if (e_idok) chk("inst_rdata", inst_bus.rdata, mem_bus.rdata);
        if (e_ddok) chk("data_rdata", data_bus.rdata, mem_bus.rdata);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("inst_grant_cnt", inst_cnt, 32'(m_inst_cnt));
        chk("data_grant_cnt", data_cnt, 32'(m_data_cnt));
`endif
    endtask

    task automatic adv();
        @(posedge clk);
        if (reset) begin
            owner = 0; accepted = 0; starve = 0; m_inst_cnt = 0; m_data_cnt = 0;
        end else begin
            if (e_iaok) m_inst_cnt++;
            if (e_daok) m_data_cnt++;
            if (owner == 0) begin
                if (data_bus.req && (!inst_bus.req || starve < SL)) begin
                    owner = 2;
                    if (inst_bus.req) starve = (starve + 1 > SL) ? SL : starve + 1;
                end else if (inst_bus.req) begin
                    owner = 1;
                    starve = 0;
                end
            end else if (!accepted) begin
                if (e_req && mem_bus.addr_ok) accepted = 1;
                else if (!e_req) owner = 0;
            end else if (mem_bus.data_ok) begin
                owner = 0;
                accepted = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 0; inst_bus.wstrb = 0;
        inst_bus.addr = 0; inst_bus.wdata = 0;
        data_bus.req = 0; data_bus.wr = 0; data_bus.size = 0; data_bus.wstrb = 0;
        data_bus.addr = 0; data_bus.wdata = 0;
        mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        idle_inputs();
        eval();
        adv();
        reset = 0;
    endtask

    // Port answers immediately; returns which master got the next addr_ok.
    task automatic wait_grant(input bit hold_data, output int who);
        who = 0;
        for (int i = 0; i < 12 && who == 0; i++) begin
            mem_bus.addr_ok = 1;
            mem_bus.data_ok = 1;
            mem_bus.rdata = $urandom;
            eval();
            if (e_iaok) who = 1;
            else if (e_daok) who = 2;
            if (who != 0) begin
                cap_addr = mem_bus.addr; cap_wdata = mem_bus.wdata;
                cap_wstrb = mem_bus.wstrb; cap_wr = mem_bus.wr;
            end
            adv();
            if (who == 1) inst_bus.req = 0;
            if (who == 2 && !hold_data) data_bus.req = 0;
        end
        if (who == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout actual=none required=a grant within 12 cycles");
        end
    endtask

    task automatic drive_random();
        reset = ($urandom_range(0, 299) == 0);
        if (reset) begin
            inst_bus.req = 0;
            data_bus.req = 0;
        end else begin
            if (inst_bus.req && e_iaok) inst_bus.req = 0;
            else if (!inst_bus.req && $urandom_range(0, 2) == 0) begin
                inst_bus.req = 1;
                inst_bus.addr = $urandom;
            end
            if (data_bus.req && e_daok) data_bus.req = 0;
            else if (data_bus.req && $urandom_range(0, 63) == 0) data_bus.req = 0;
            else if (!data_bus.req && $urandom_range(0, 1) == 0) begin
                data_bus.req = 1;
                data_bus.wr = 1'($urandom);
                data_bus.size = 2'($urandom_range(0, 2));
                data_bus.wstrb = 4'($urandom);
                data_bus.addr = $urandom;
                data_bus.wdata = $urandom;
            end
        end
        mem_bus.addr_ok = ($urandom_range(0, 2) != 0);
        mem_bus.data_ok = 1'($urandom);
        mem_bus.rdata = $urandom;
    endtask

    initial begin
        int who;
        int order[4];
        int exp_order[4];

        reset = 1;
        idle_inputs();
        adv();
        adv();
        eval();
        chk("reset_mem_req", 32'(mem_bus.req), 32'd0);
        chk("reset_addr_ok", 32'({inst_bus.addr_ok, data_bus.addr_ok}), 32'd0);
        chk("reset_data_ok", 32'({inst_bus.data_ok, data_bus.data_ok}), 32'd0);
        adv();
        reset = 0;

        // Lone instruction fetch.
        inst_bus.req = 1;
        inst_bus.addr = 32'h1C00_0000;
        eval();
        chk("fetch_idle_no_req", 32'(mem_bus.req), 32'd0);
        adv();
        mem_bus.addr_ok = 1;
        eval();
        chk("fetch_mem_req", 32'(mem_bus.req), 32'd1);
        chk("fetch_mem_addr", mem_bus.addr, 32'h1C00_0000);
        chk("fetch_mem_size", 32'(mem_bus.size), 32'd2);
        chk("fetch_addr_ok", 32'(inst_bus.addr_ok), 32'd1);
        adv();
        inst_bus.req = 0;
        mem_bus.addr_ok = 0;
        mem_bus.data_ok = 1;
        mem_bus.rdata = 32'h0280_0000;
        eval();
        chk("fetch_resp_no_req", 32'(mem_bus.req), 32'd0);
        chk("fetch_data_ok", 32'(inst_bus.data_ok), 32'd1);
        chk("fetch_rdata", inst_bus.rdata, 32'h0280_0000);
        chk("fetch_data_side_quiet", 32'({data_bus.addr_ok, data_bus.data_ok}), 32'd0);
        adv();
        mem_bus.data_ok = 0;

        // Store and fetch together: store wins, fetch follows.
        pulse_reset();
        inst_bus.req = 1; inst_bus.addr = 32'h1C00_0004;
        data_bus.req = 1; data_bus.wr = 1; data_bus.size = 2'd1; data_bus.wstrb = 4'b0011;
        data_bus.addr = 32'h100; data_bus.wdata = 32'hABCD;
        wait_grant(1'b0, who);
        chk("store_first", 32'(who), 32'd2);
        chk("store_wstrb", 32'(cap_wstrb), 32'h3);
        chk("store_wr", 32'(cap_wr), 32'd1);
        chk("store_addr", cap_addr, 32'h100);
        chk("store_wdata", cap_wdata, 32'hABCD);
        wait_grant(1'b0, who);
        chk("fetch_after_store", 32'(who), 32'd1);

        // Continuous data traffic: instruction forced in after SL data wins.
        pulse_reset();
        inst_bus.req = 1; inst_bus.addr = 32'h1C00_0008;
        data_bus.req = 1; data_bus.wr = 0; data_bus.size = 2'd2; data_bus.wstrb = 0;
        data_bus.addr = 32'h200;
        exp_order[0] = 2; exp_order[1] = 2; exp_order[2] = 1; exp_order[3] = 2;
        for (int g = 0; g < 4; g++) begin
            wait_grant(1'b1, order[g]);
            chk($sformatf("starve_grant%0d", g), 32'(order[g]), 32'(exp_order[g]));
        end
        data_bus.req = 0;

        // Port stalls addr_ok, then reset lands in the response phase.
        pulse_reset();
        mem_bus.addr_ok = 0;
        inst_bus.req = 1; inst_bus.addr = 32'h0000_2000;
        eval();
        adv();
        for (int s = 0; s < 5; s++) begin
            eval();
            chk("stall_req_held", 32'(mem_bus.req), 32'd1);
            chk("stall_addr_held", mem_bus.addr, 32'h0000_2000);
            chk("stall_no_addr_ok", 32'({inst_bus.addr_ok, data_bus.addr_ok}), 32'd0);
            adv();
        end
        mem_bus.addr_ok = 1;
        eval();
        chk("stall_accept", 32'(inst_bus.addr_ok), 32'd1);
        adv();
        inst_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 0;
        reset = 1;
        eval();
        adv();
        reset = 0;
        mem_bus.data_ok = 1;
        eval();
        chk("late_data_ok_dropped", 32'({inst_bus.data_ok, data_bus.data_ok}), 32'd0);
        chk("after_reset_no_req", 32'(mem_bus.req), 32'd0);
        adv();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            eval();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
